// File: rtl/inst_fetch_unit.sv
// Instruction-fetch master: drives the ROM and buffers {pc, inst} pairs in an in-order queue toward decode.
// Latency: first push two edges after reset release; a pushed entry is visible on id_* the cycle after its fetch.
// Backpressure: a full queue with no pop drops rom_ce and holds pc; a redirect flushes the queue and blocks fetch/pop.
// Optional feature macro FETCH_PERF_EN: enables the queue-full stall and redirect counters on perf_*_o.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic                           rom_ce,
    output logic [31:0]                    rom_addr,
    input  logic [31:0]                    rom_inst,
    input  logic                           branch_flag_i,
    input  logic [31:0]                    branch_target_i,
    input  logic                           id_ready_i,
    output logic                           id_valid_o,
    output logic [31:0]                    id_inst_o,
    output logic [31:0]                    id_pc_o,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count_o,
    output logic [31:0]                    perf_stall_o,
    output logic [31:0]                    perf_flush_o
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

    // Architectural fetch state
    logic [31:0]      pc_q, pc_d;
    logic             ce_q;

    // Queue bookkeeping; pointers wrap naturally because the depth is a power of two
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Queue storage; contents need no reset because count gates every read
    logic [31:0]      q_pc_mem   [QUEUE_DEPTH];
    logic [31:0]      q_inst_mem [QUEUE_DEPTH];

    // Per-cycle handshake terms
    logic             not_empty;
    logic             full;
    logic             pop;
    logic             push;
    logic [31:0]      redirect_pc;

    // The low two target bits are discarded on a redirect (word-aligned fetch)
    logic             unused_target_lsbs;
    assign unused_target_lsbs = ^branch_target_i[1:0];

    assign redirect_pc = {branch_target_i[31:2], 2'b00};

    // Output view and fetch decision; a redirect masks both valid and chip enable
    always_comb begin
        not_empty     = (count_q != '0);
        full          = (count_q == FULL_CNT);
        id_valid_o    = not_empty & ~branch_flag_i;
        pop           = id_valid_o & id_ready_i;
        rom_ce        = ce_q & (~full | pop) & ~branch_flag_i;
        push          = rom_ce;
        rom_addr      = pc_q;
        queue_count_o = count_q;
        id_pc_o       = '0;
        id_inst_o     = '0;
        if (not_empty) begin
            id_pc_o   = q_pc_mem[head_q];
            id_inst_o = q_inst_mem[head_q];
        end
    end

    // Next-state for pc and queue pointers; a redirect overrides push and pop
    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (branch_flag_i) begin
            pc_d    = redirect_pc;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                pc_d   = pc_q + 32'd4;
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State register; reset wins over any redirect in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            ce_q    <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            ce_q    <= 1'b1;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Tail write of the fetched {pc, inst} pair
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            q_pc_mem[tail_q]   <= pc_q;
            q_inst_mem[tail_q] <= rom_inst;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters: full-queue stall cycles and taken redirects
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (ce_q && full && !pop && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (branch_flag_i && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_o = stall_cnt_q;
    assign perf_flush_o = flush_cnt_q;
`else
    assign perf_stall_o = '0;
    assign perf_flush_o = '0;
`endif

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction-fetch master; drives the instruction ROM's chip-enable and byte address and consumes its combinational instruction word.
- Runs ahead of decode, buffering {pc, inst} pairs in a small in-order queue.
- Handles downstream back-pressure and branch redirects; the queue head feeds the IF/ID boundary over a valid/ready handshake.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset (word aligned).
- QUEUE_DEPTH, 4, instruction queue entries; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- rom_ce  output  1  ROM chip enable (1 = enabled)
- rom_addr  output  32  ROM byte address; always equals pc
- rom_inst  input  32  ROM instruction word, valid in the same cycle as rom_addr when rom_ce=1
- branch_flag_i  input  1  redirect request from execute
- branch_target_i  input  32  redirect byte address
- id_ready_i  input  1  decode accepts the head entry this cycle
- id_valid_o  output  1  head entry valid
- id_inst_o  output  32  head instruction
- id_pc_o  output  32  head instruction's address
- queue_count_o  output  log2(QUEUE_DEPTH)+1  occupied entries
- perf_stall_o  output  32  cycles with queue full (see Optional Feature)
- perf_flush_o  output  32  redirects taken (see Optional Feature)

Behaviour:
- Reset, with rst sampled high at an edge:
  - pc=RESET_PC, ce_q=0, queue empty, pointers=0, perf counters=0.
  - Outputs: rom_ce=0, rom_addr=RESET_PC, id_valid_o=0, id_inst_o=0, id_pc_o=0, queue_count_o=0.
- ce_q is set to 1 at the first edge with rst=0 and stays 1 until the next reset.
- pop = id_valid_o & id_ready_i.
- Fetch condition:
  - space = (count < QUEUE_DEPTH) | pop.
  - rom_ce = ce_q & space & ~branch_flag_i.
  - fetch = rom_ce.
- On fetch:
  - {pc, rom_inst} is written at the tail; tail advances.
  - pc <= pc + 4, wrapping 32'hFFFFFFFC -> 32'h00000000.
- When rom_ce=0 and there is no redirect, pc holds.
- Output view:
  - id_valid_o = (count != 0) & ~branch_flag_i.
  - id_inst_o / id_pc_o show the head entry when count != 0, else 0.
- On pop, the head advances. Push and pop in the same cycle leave count unchanged; this is allowed when full.
- Redirect (branch_flag_i=1, rst=0):
  - Queue is flushed: count=0, head=tail=0.
  - pc <= {branch_target_i[31:2], 2'b00}; low two bits are discarded.
  - No push or pop that cycle.
  - The target instruction is fetched next cycle and is visible on id_* the cycle after.
- Latency:
  - After rst falls, the first edge sets ce_q.
  - The second edge pushes RESET_PC's word.
  - id_valid_o is high from the cycle after that second edge.
  - Steady state with id_ready_i=1: one instruction per cycle.
- Full with no pop: rom_ce=0, pc holds, no entry is overwritten.
- Empty: id_valid_o=0 and id_ready_i is ignored.
- Pointers wrap modulo QUEUE_DEPTH.
- Simultaneous events:
  - rst has priority over branch_flag_i.
  - branch_flag_i has priority over fetch and pop.
  - Reset mid-stream discards all queued entries.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - perf_stall_o increments each cycle with ce_q=1, count=QUEUE_DEPTH and no pop.
  - perf_flush_o increments each redirect cycle.
  - Both saturate at 32'hFFFFFFFF and clear on rst.
- Undefined: both ports are present and tied to 0; no counter logic is generated.

Test Plan:
- Reset release, ROM word n = 32'h1000_0000+n, id_ready_i=1 -> id_valid_o rises 2 cycles after rst low; id_pc_o sequence 0x0,0x4,0x8; id_inst_o 0x10000000,0x10000001,0x10000002.
- id_ready_i=0 from reset -> exactly 4 pushes; queue_count_o=4; rom_ce=0; rom_addr holds 0x10. Then id_ready_i=1 -> pops resume with 0x0 first, no loss or duplication. perf_stall_o counts the full cycles when FETCH_PERF_EN is defined.
- Queue holds 3 entries; branch_flag_i=1 with target 0x0000_0103 for one cycle -> id_valid_o=0 that cycle, queue_count_o=0 next cycle, next id_pc_o=0x100, perf_flush_o=1.
- rst and branch_flag_i asserted together -> pc=RESET_PC; the branch is ignored.
- pc preset near the top via branch to 0xFFFFFFF8 -> fetched id_pc_o sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Random id_ready_i with occasional branches versus a scoreboard model -> in-order delivery, no entry returned after a flush, queue_count_o never exceeds 4.
